// File: rtl/axi_read_pkg.sv
// Shared AXI3 read-channel encodings, AR attribute bundle and arbiter FSM states.
package axi_read_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE1 = 2'd0,
      SIZE_BYTE2 = 2'd1,
      SIZE_BYTE4 = 2'd2
   } ar_size_e;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } ar_burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } r_resp_e;

   // Fields are plain vectors so reserved encodings pass through untouched.
   typedef struct packed {
      logic [3:0] len;
      logic [1:0] size;
      logic [1:0] burst;
      logic [1:0] lock;
      logic [3:0] cache;
      logic [2:0] prot;
   } ar_attr_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer master wins ties and the pointer
// moves past the winner on each advance strobe.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant_c,
   output logic       any_c
);
   logic ptr_q;

   assign any_c   = |req;
   assign grant_c = req[ptr_q] ? ptr_q : ~ptr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (advance) begin
         ptr_q <= ~grant_c;
      end
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read slave port between two masters: round-robin AR issue
// through a registered stage, RID-MSB routing of R beats, outstanding-burst limits.
module axi_read_arbiter #(
   parameter int unsigned BUSWIDTH    = 32,
   parameter int unsigned MASTER_TAGS = 1,
   parameter int unsigned MAX_OUTST   = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [MASTER_TAGS-1:0] m0_ARID,
   input  logic [BUSWIDTH-1:0]    m0_ARADDR,
   input  logic [3:0]             m0_ARLEN,
   input  logic [1:0]             m0_ARSIZE,
   input  logic [1:0]             m0_ARBURST,
   input  logic [1:0]             m0_ARLOCK,
   input  logic [3:0]             m0_ARCACHE,
   input  logic [2:0]             m0_ARPROT,
   input  logic                   m0_ARVALID,
   output logic                   m0_ARREADY,
   input  logic [MASTER_TAGS-1:0] m1_ARID,
   input  logic [BUSWIDTH-1:0]    m1_ARADDR,
   input  logic [3:0]             m1_ARLEN,
   input  logic [1:0]             m1_ARSIZE,
   input  logic [1:0]             m1_ARBURST,
   input  logic [1:0]             m1_ARLOCK,
   input  logic [3:0]             m1_ARCACHE,
   input  logic [2:0]             m1_ARPROT,
   input  logic                   m1_ARVALID,
   output logic                   m1_ARREADY,
   output logic [MASTER_TAGS:0]   s_ARID,
   output logic [BUSWIDTH-1:0]    s_ARADDR,
   output logic [3:0]             s_ARLEN,
   output logic [1:0]             s_ARSIZE,
   output logic [1:0]             s_ARBURST,
   output logic [1:0]             s_ARLOCK,
   output logic [3:0]             s_ARCACHE,
   output logic [2:0]             s_ARPROT,
   output logic                   s_ARVALID,
   input  logic                   s_ARREADY,
   input  logic [MASTER_TAGS:0]   s_RID,
   input  logic [BUSWIDTH-1:0]    s_RDATA,
   input  logic [1:0]             s_RRESP,
   input  logic                   s_RLAST,
   input  logic                   s_RVALID,
   output logic                   s_RREADY,
   output logic [MASTER_TAGS-1:0] m0_RID,
   output logic [BUSWIDTH-1:0]    m0_RDATA,
   output logic [1:0]             m0_RRESP,
   output logic                   m0_RLAST,
   output logic                   m0_RVALID,
   input  logic                   m0_RREADY,
   output logic [MASTER_TAGS-1:0] m1_RID,
   output logic [BUSWIDTH-1:0]    m1_RDATA,
   output logic [1:0]             m1_RRESP,
   output logic                   m1_RLAST,
   output logic                   m1_RVALID,
   input  logic                   m1_RREADY,
   output logic                   err_unexp_r
);
   import axi_read_pkg::*;

   localparam int unsigned IDW = MASTER_TAGS + 1;

   arb_state_e          state_q, state_d;
   logic                ar_fire_c, grant_c, any_elig_c;
   logic                r_sel_c, r_last_hs_c;
   logic [1:0]          elig_c, inc_c, dec_c;
   logic [CNT_W-1:0]    cnt_q [2];
   logic [CNT_W-1:0]    cnt_d [2];
   logic                err_q, err_d;
   logic                ar_valid_q;
   logic [IDW-1:0]      ar_id_q;
   logic [BUSWIDTH-1:0] ar_addr_q;
   ar_attr_t            ar_attr_q, m0_attr_c, m1_attr_c;

   assign m0_attr_c = '{len: m0_ARLEN, size: m0_ARSIZE, burst: m0_ARBURST,
                        lock: m0_ARLOCK, cache: m0_ARCACHE, prot: m0_ARPROT};
   assign m1_attr_c = '{len: m1_ARLEN, size: m1_ARSIZE, burst: m1_ARBURST,
                        lock: m1_ARLOCK, cache: m1_ARCACHE, prot: m1_ARPROT};

   assign elig_c[0] = m0_ARVALID && (cnt_q[0] < CNT_W'(MAX_OUTST));
   assign elig_c[1] = m1_ARVALID && (cnt_q[1] < CNT_W'(MAX_OUTST));

   rr_arbiter2 u_arb (
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .req     (elig_c),
      .advance (ar_fire_c),
      .grant_c (grant_c),
      .any_c   (any_elig_c)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Accept only in IDLE, and never while reset is held.
   always_comb begin
      state_d   = state_q;
      ar_fire_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_elig_c && ARESETn) begin
               ar_fire_c = 1'b1;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (s_ARREADY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m0_ARREADY = ar_fire_c && !grant_c;
   assign m1_ARREADY = ar_fire_c && grant_c;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_attr_q  <= '0;
      end else if (ar_fire_c) begin
         ar_valid_q <= 1'b1;
         ar_id_q    <= grant_c ? {1'b1, m1_ARID} : {1'b0, m0_ARID};
         ar_addr_q  <= grant_c ? m1_ARADDR : m0_ARADDR;
         ar_attr_q  <= grant_c ? m1_attr_c : m0_attr_c;
      end else if (s_ARREADY) begin
         ar_valid_q <= 1'b0;
      end
   end

   assign s_ARVALID = ar_valid_q;
   assign s_ARID    = ar_id_q;
   assign s_ARADDR  = ar_addr_q;
   assign s_ARLEN   = ar_attr_q.len;
   assign s_ARSIZE  = ar_attr_q.size;
   assign s_ARBURST = ar_attr_q.burst;
   assign s_ARLOCK  = ar_attr_q.lock;
   assign s_ARCACHE = ar_attr_q.cache;
   assign s_ARPROT  = ar_attr_q.prot;

   // R channel: zero-latency steering on the ID bit prepended at issue.
   assign r_sel_c     = s_RID[MASTER_TAGS];
   assign s_RREADY    = r_sel_c ? m1_RREADY : m0_RREADY;
   assign r_last_hs_c = s_RVALID && s_RREADY && s_RLAST;
   assign m0_RVALID   = s_RVALID && !r_sel_c;
   assign m1_RVALID   = s_RVALID && r_sel_c;
   assign m0_RID      = s_RID[MASTER_TAGS-1:0];
   assign m1_RID      = s_RID[MASTER_TAGS-1:0];
   assign m0_RDATA    = s_RDATA;
   assign m1_RDATA    = s_RDATA;
   assign m0_RRESP    = s_RRESP;
   assign m1_RRESP    = s_RRESP;
   assign m0_RLAST    = s_RLAST;
   assign m1_RLAST    = s_RLAST;

   assign inc_c = {ar_fire_c && grant_c, ar_fire_c && !grant_c};
   assign dec_c = {r_last_hs_c && r_sel_c, r_last_hs_c && !r_sel_c};

   // Outstanding counters; a completion against an empty counter is flagged.
   always_comb begin
      err_d = err_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_c[i] && !dec_c[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec_c[i] && !inc_c[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         if (dec_c[i] && (cnt_q[i] == '0)) err_d = 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
         err_q    <= 1'b0;
      end else begin
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
         err_q    <= err_d;
      end
   end

   assign err_unexp_r = err_q;

endmodule
